adder_result_checker: RTL
=========================

Name: adder_result_checker

Overview:
Downstream consumer of the 4-bit adder's 5-bit sum. It samples each operand/sum triple, recomputes the expected sum, and keeps pass/fail counts over a fixed-length run of LENGTH vectors. It replaces display-based checking in adder benches and regressions with a synthesizable scoreboard that raises done when the run is complete.

Parameters:
WIDTH, 4, operand width; sum width is WIDTH+1
LENGTH, 6, number of vectors accepted per run
CNT_W, 8, width of the pass/fail counters and the vector index

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  starts a run; honoured in IDLE and DONE only
in_valid  in  1  operand/sum triple present this cycle
in_a  in  WIDTH  operand A fed to the adder
in_b  in  WIDTH  operand B fed to the adder
in_sum  in  WIDTH+1  adder output under check
busy  out  1  high in RUN
done  out  1  high in DONE
pass_cnt  out  CNT_W  matching vectors this run
fail_cnt  out  CNT_W  mismatching vectors this run
err_valid  out  1  one-cycle pulse per mismatch
err_a  out  WIDTH  A of the most recent mismatch
err_b  out  WIDTH  B of the most recent mismatch
err_sum  out  WIDTH+1  in_sum of the most recent mismatch
first_fail_idx  out  CNT_W  0-based index of the first mismatching vector; holds all-ones when there is no fail

Behaviour:
- Reset (async, rst=1): state IDLE, every output 0 except first_fail_idx=all-ones, pipeline valids cleared. rst asserted mid-run aborts the run immediately and discards any in-flight vector.
- FSM states:
  - IDLE --start--> RUN.
  - RUN --(accepted==LENGTH and pipeline empty)--> DONE.
  - DONE --start--> RUN.
  - start in RUN is ignored.
- Entering RUN (the cycle start is sampled): clear pass_cnt, fail_cnt, err_* and the accepted-vector index; set first_fail_idx to all-ones.
- Accept rule: a vector is accepted when state==RUN, in_valid=1 and accepted<LENGTH.
  - in_valid outside RUN is ignored.
  - in_valid after LENGTH vectors have been accepted is ignored.
  - Gaps in in_valid are allowed.
- Stage 1 (edge after accept): register a, b, sum and the vector index; compute exp = zero-extended a + zero-extended b at WIDTH+1 bits. No truncation, so 15+15 gives exp=30.
- Stage 2 (next edge): compare the registered sum with exp.
  - Match: pass_cnt+1.
  - Mismatch: fail_cnt+1; err_valid=1 for exactly one cycle; err_a/err_b/err_sum load the vector's values; first_fail_idx loads the index only if it is still all-ones.
- Latency: counters and err_* update on the 2nd rising edge after the accepting edge. Back-to-back accepts give one update per cycle.
- Counters saturate at 2^CNT_W-1 and never wrap.
- done rises on the edge after the last vector's stage-2 update. From then on it stays high and the counters hold until the next start or rst.
- busy equals (state==RUN); busy and done are never both 1.
- LENGTH must be between 1 and 2^CNT_W-2 inclusive, so a valid index can never equal the all-ones sentinel.

Decomposition:
- Package adder_check_pkg contains:
  - the state enum {IDLE, RUN, DONE};
  - the defaults WIDTH=4 and LENGTH=6;
  - the localparam SUM_W=WIDTH+1.
- Sub-module sum_compare_stage holds the two-stage register/compare pipeline: inputs valid/a/b/sum/idx; outputs match_valid, mismatch, and the registered a/b/sum/idx.
- adder_result_checker contains the FSM, the accept logic, the counters and the error capture.

Test Plan:
- Basic run: start, then 6 vectors a=b=0..5 with sum=2a on consecutive cycles -> pass_cnt=6, fail_cnt=0, err_valid never high, done high 3 cycles after the last accept, first_fail_idx=all-ones.
- Single error: same run but the vector at index 3 carries sum=7 instead of 6 -> fail_cnt=1, pass_cnt=5, one err_valid pulse with err_a=3, err_b=3, err_sum=7, first_fail_idx=3.
- Width edge: LENGTH=2, vectors (15,15,30) then (15,15,14) -> pass_cnt=1, fail_cnt=1, err_sum=14, first_fail_idx=1.
- Gaps and extras: in_valid toggles every other cycle for 6 vectors, then 3 extra in_valid cycles in DONE, plus in_valid before start -> exactly 6 vectors counted.
- Reset mid-run: rst pulse after 3 accepts -> immediately IDLE, all outputs 0, first_fail_idx=all-ones. A fresh start then gives pass_cnt=6.
- Restart from DONE: start after a run that ended with fail_cnt=1 -> counters clear on entering RUN; a clean second run ends with pass_cnt=6, fail_cnt=0.

Source files
------------

// File: rtl/adder_check_pkg.sv
// rtl/adder_check_pkg.sv - shared types and default sizes for the adder result checker
package adder_check_pkg;
    localparam int DEF_WIDTH  = 4;
    localparam int DEF_LENGTH = 6;
    localparam int DEF_CNT_W  = 8;
    localparam int SUM_W      = DEF_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;
endpackage

// File: rtl/sum_compare_stage.sv
// rtl/sum_compare_stage.sv - two-stage register/compare pipeline for one adder result
module sum_compare_stage #(
    parameter int WIDTH = adder_check_pkg::DEF_WIDTH,
    parameter int SUM_W = adder_check_pkg::SUM_W,
    parameter int IDX_W = adder_check_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SUM_W-1:0] sum,
    input  logic [IDX_W-1:0] idx,
    output logic             pipe_busy,
    output logic             match_valid,
    output logic             mismatch,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic [SUM_W-1:0] reg_sum,
    output logic [IDX_W-1:0] reg_idx
);
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [SUM_W-1:0] s1_sum_q, s1_sum_d, s1_exp_q, s1_exp_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
    logic             s2_valid_q, s2_valid_d, s2_mismatch_q, s2_mismatch_d;
    logic [WIDTH-1:0] s2_a_q, s2_a_d, s2_b_q, s2_b_d;
    logic [SUM_W-1:0] s2_sum_q, s2_sum_d;
    logic [IDX_W-1:0] s2_idx_q, s2_idx_d;

    always_comb begin
        s1_valid_d = valid;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_sum_d   = s1_sum_q;
        s1_idx_d   = s1_idx_q;
        s1_exp_d   = s1_exp_q;
        if (valid) begin
            s1_a_d   = a;
            s1_b_d   = b;
            s1_sum_d = sum;
            s1_idx_d = idx;
            // operands are widened first so the carry out is kept
            s1_exp_d = SUM_W'(a) + SUM_W'(b);
        end

        s2_valid_d    = s1_valid_q;
        s2_mismatch_d = s1_valid_q && (s1_sum_q != s1_exp_q);
        s2_a_d        = s2_a_q;
        s2_b_d        = s2_b_q;
        s2_sum_d      = s2_sum_q;
        s2_idx_d      = s2_idx_q;
        if (s1_valid_q) begin
            s2_a_d   = s1_a_q;
            s2_b_d   = s1_b_q;
            s2_sum_d = s1_sum_q;
            s2_idx_d = s1_idx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_sum_q      <= '0;
            s1_idx_q      <= '0;
            s1_exp_q      <= '0;
            s2_valid_q    <= 1'b0;
            s2_mismatch_q <= 1'b0;
            s2_a_q        <= '0;
            s2_b_q        <= '0;
            s2_sum_q      <= '0;
            s2_idx_q      <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_sum_q      <= s1_sum_d;
            s1_idx_q      <= s1_idx_d;
            s1_exp_q      <= s1_exp_d;
            s2_valid_q    <= s2_valid_d;
            s2_mismatch_q <= s2_mismatch_d;
            s2_a_q        <= s2_a_d;
            s2_b_q        <= s2_b_d;
            s2_sum_q      <= s2_sum_d;
            s2_idx_q      <= s2_idx_d;
        end
    end

    assign pipe_busy   = s1_valid_q | s2_valid_q;
    assign match_valid = s2_valid_q;
    assign mismatch    = s2_mismatch_q;
    assign reg_a       = s2_a_q;
    assign reg_b       = s2_b_q;
    assign reg_sum     = s2_sum_q;
    assign reg_idx     = s2_idx_q;
endmodule

// File: rtl/adder_result_checker.sv
// rtl/adder_result_checker.sv - pass/fail scoreboard for adder results over a fixed-length run
module adder_result_checker
    import adder_check_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LENGTH = DEF_LENGTH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_valid,
    output logic [WIDTH-1:0] err_a,
    output logic [WIDTH-1:0] err_b,
    output logic [WIDTH:0]   err_sum,
    output logic [CNT_W-1:0] first_fail_idx
);
    localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(LENGTH);
    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    state_e           state_q, state_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0] accepted_q, accepted_d, pass_q, pass_d, fail_q, fail_d, ffi_q, ffi_d;
    logic             err_valid_q, err_valid_d;
    logic [WIDTH-1:0] err_a_q, err_a_d, err_b_q, err_b_d;
    logic [WIDTH:0]   err_sum_q, err_sum_d;

    logic             accept, start_run, pipe_busy, match_valid, mismatch;
    logic [WIDTH-1:0] reg_a, reg_b;
    logic [WIDTH:0]   reg_sum;
    logic [CNT_W-1:0] reg_idx;

    assign start_run = start && (state_q != RUN);
    assign accept    = (state_q == RUN) && in_valid && (accepted_q < LEN_C);

    sum_compare_stage #(
        .WIDTH(WIDTH),
        .SUM_W(WIDTH + 1),
        .IDX_W(CNT_W)
    ) u_cmp (
        .clk        (clk),
        .rst        (rst),
        .valid      (accept),
        .a          (in_a),
        .b          (in_b),
        .sum        (in_sum),
        .idx        (accepted_q),
        .pipe_busy  (pipe_busy),
        .match_valid(match_valid),
        .mismatch   (mismatch),
        .reg_a      (reg_a),
        .reg_b      (reg_b),
        .reg_sum    (reg_sum),
        .reg_idx    (reg_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accepted_q == LEN_C && !pipe_busy) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_comb begin
        accepted_d  = accepted_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        ffi_d       = ffi_q;
        err_valid_d = 1'b0;
        err_a_d     = err_a_q;
        err_b_d     = err_b_q;
        err_sum_d   = err_sum_q;
        if (start_run) begin
            accepted_d = '0;
            pass_d     = '0;
            fail_d     = '0;
            ffi_d      = ALL_ONES;
            err_a_d    = '0;
            err_b_d    = '0;
            err_sum_d  = '0;
        end else begin
            if (accept) accepted_d = accepted_q + 1'b1;
            if (match_valid && !mismatch && pass_q != ALL_ONES) pass_d = pass_q + 1'b1;
            if (match_valid && mismatch) begin
                if (fail_q != ALL_ONES) fail_d = fail_q + 1'b1;
                err_valid_d = 1'b1;
                err_a_d     = reg_a;
                err_b_d     = reg_b;
                err_sum_d   = reg_sum;
                // all-ones doubles as "no fail yet" since LENGTH keeps indices below it
                if (ffi_q == ALL_ONES) ffi_d = reg_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            accepted_q  <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            ffi_q       <= ALL_ONES;
            err_valid_q <= 1'b0;
            err_a_q     <= '0;
            err_b_q     <= '0;
            err_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            accepted_q  <= accepted_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            ffi_q       <= ffi_d;
            err_valid_q <= err_valid_d;
            err_a_q     <= err_a_d;
            err_b_q     <= err_b_d;
            err_sum_q   <= err_sum_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign err_valid      = err_valid_q;
    assign err_a          = err_a_q;
    assign err_b          = err_b_q;
    assign err_sum        = err_sum_q;
    assign first_fail_idx = ffi_q;
endmodule
